// File: rtl/jtag_pkg.sv
// TAP state encodings, DR select codes and capture constants shared by the TAP controller and core.
// State values match the existing TAP controller so STATE traces stay comparable across generations.
package jtag_pkg;

    localparam logic [3:0] ST_TEST_LOGIC_RESET = 4'h0;
    localparam logic [3:0] ST_RUN_TEST_IDLE    = 4'h1;
    localparam logic [3:0] ST_SELECT_DR        = 4'h2;
    localparam logic [3:0] ST_CAPTURE_DR       = 4'h3;
    localparam logic [3:0] ST_SHIFT_DR         = 4'h4;
    localparam logic [3:0] ST_EXIT1_DR         = 4'h5;
    localparam logic [3:0] ST_PAUSE_DR         = 4'h6;
    localparam logic [3:0] ST_EXIT2_DR         = 4'h7;
    localparam logic [3:0] ST_UPDATE_DR        = 4'h8;
    localparam logic [3:0] ST_SELECT_IR        = 4'h9;
    localparam logic [3:0] ST_CAPTURE_IR       = 4'hA;
    localparam logic [3:0] ST_SHIFT_IR         = 4'hB;
    localparam logic [3:0] ST_EXIT1_IR         = 4'hC;
    localparam logic [3:0] ST_PAUSE_IR         = 4'hD;
    localparam logic [3:0] ST_EXIT2_IR         = 4'hE;
    localparam logic [3:0] ST_UPDATE_IR        = 4'hF;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = ST_TEST_LOGIC_RESET,
        RUN_TEST_IDLE    = ST_RUN_TEST_IDLE,
        SELECT_DR        = ST_SELECT_DR,
        CAPTURE_DR       = ST_CAPTURE_DR,
        SHIFT_DR         = ST_SHIFT_DR,
        EXIT1_DR         = ST_EXIT1_DR,
        PAUSE_DR         = ST_PAUSE_DR,
        EXIT2_DR         = ST_EXIT2_DR,
        UPDATE_DR        = ST_UPDATE_DR,
        SELECT_IR        = ST_SELECT_IR,
        CAPTURE_IR       = ST_CAPTURE_IR,
        SHIFT_IR         = ST_SHIFT_IR,
        EXIT1_IR         = ST_EXIT1_IR,
        PAUSE_IR         = ST_PAUSE_IR,
        EXIT2_IR         = ST_EXIT2_IR,
        UPDATE_IR        = ST_UPDATE_IR
    } tap_state_t;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_USER
    } dr_sel_t;

    localparam logic [1:0] IR_CAPTURE     = 2'b01;
    localparam logic       BYPASS_CAPTURE = 1'b0;
    localparam int         IDCODE_WIDTH   = 32;

    function automatic logic is_shift_state(input tap_state_t s);
        return (s == SHIFT_DR) || (s == SHIFT_IR);
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller state register; STATE follows TMS one TCK posedge later.
// No backpressure: advances on every TCK posedge, TRST forces TEST_LOGIC_RESET asynchronously.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output tap_state_t STATE
);

    tap_state_t state_q;
    tap_state_t state_d;

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state_q <= TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TEST_LOGIC_RESET: state_d = TMS ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_d = TMS ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_DR:        state_d = TMS ? SELECT_IR        : CAPTURE_DR;
            CAPTURE_DR:       state_d = TMS ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         state_d = TMS ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         state_d = TMS ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         state_d = TMS ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         state_d = TMS ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        state_d = TMS ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_IR:        state_d = TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = TMS ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         state_d = TMS ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         state_d = TMS ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         state_d = TMS ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         state_d = TMS ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        state_d = TMS ? SELECT_DR        : RUN_TEST_IDLE;
            default:          state_d = TEST_LOGIC_RESET;
        endcase
    end

    assign STATE = state_q;

endmodule

// File: rtl/jtag_tap_core.sv
// JTAG TAP with instruction register, BYPASS, IDCODE and one user DR with parallel capture/update.
// Latency: STATE one posedge after TMS, TDO on the following negedge; no backpressure, TCK-paced.
module jtag_tap_core
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VAL   = 32'h1577_B001,
    parameter logic [3:0]  IDCODE_INSTR = 4'b0001,
    parameter logic [3:0]  USER_INSTR   = 4'b0010,
    parameter int          USER_WIDTH   = 8
) (
    input  logic                  TCK,
    input  logic                  TRST,
    input  logic                  TMS,
    input  logic                  TDI,
    output logic                  TDO,
    output logic                  TDO_EN,
    output logic [3:0]            STATE,
    output logic [IR_WIDTH-1:0]   IR_OUT,
    input  logic [USER_WIDTH-1:0] USER_CAP,
    output logic [USER_WIDTH-1:0] USER_UPD,
    output logic                  USER_UPD_STB
);

    localparam logic [IR_WIDTH-1:0] IDCODE_OP      = IR_WIDTH'(IDCODE_INSTR);
    localparam logic [IR_WIDTH-1:0] USER_OP        = IR_WIDTH'(USER_INSTR);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE_VAL = IR_WIDTH'(IR_CAPTURE);

    tap_state_t state;

    jtag_tap_fsm u_fsm (
        .TCK   (TCK),
        .TRST  (TRST),
        .TMS   (TMS),
        .STATE (state)
    );

    assign STATE = state;

    logic [IR_WIDTH-1:0]     ir_shift;
    logic [IR_WIDTH-1:0]     ir_shift_nxt;
    logic [IDCODE_WIDTH-1:0] idcode_shift;
    logic [USER_WIDTH-1:0]   user_shift;
    logic [USER_WIDTH-1:0]   user_shift_nxt;
    logic                    bypass_reg;
    dr_sel_t                 dr_sel;
    logic                    dr_lsb;
    logic                    tdo_nxt;

    // IDCODE is tested first so it keeps priority if both opcodes collapse to the same value.
    always_comb begin
        if (IR_OUT == IDCODE_OP) begin
            dr_sel = DR_IDCODE;
        end else if (IR_OUT == USER_OP) begin
            dr_sel = DR_USER;
        end else begin
            dr_sel = DR_BYPASS;
        end
    end

    // Written as shift-then-overwrite so widths of 1 need no special case.
    always_comb begin
        ir_shift_nxt                 = ir_shift >> 1;
        ir_shift_nxt[IR_WIDTH-1]     = TDI;
        user_shift_nxt               = user_shift >> 1;
        user_shift_nxt[USER_WIDTH-1] = TDI;
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            ir_shift <= '0;
            IR_OUT   <= IDCODE_OP;
        end else begin
            case (state)
                TEST_LOGIC_RESET: IR_OUT   <= IDCODE_OP;
                CAPTURE_IR:       ir_shift <= IR_CAPTURE_VAL;
                SHIFT_IR:         ir_shift <= ir_shift_nxt;
                UPDATE_IR:        IR_OUT   <= ir_shift;
                default:          ;
            endcase
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            idcode_shift <= '0;
            user_shift   <= '0;
            bypass_reg   <= 1'b0;
        end else if (state == CAPTURE_DR) begin
            case (dr_sel)
                DR_IDCODE: idcode_shift <= IDCODE_VAL;
                DR_USER:   user_shift   <= USER_CAP;
                default:   bypass_reg   <= BYPASS_CAPTURE;
            endcase
        end else if (state == SHIFT_DR) begin
            case (dr_sel)
                DR_IDCODE: idcode_shift <= {TDI, idcode_shift[IDCODE_WIDTH-1:1]};
                DR_USER:   user_shift   <= user_shift_nxt;
                default:   bypass_reg   <= TDI;
            endcase
        end
    end

    // The strobe is registered alongside USER_UPD so both change in the same TCK cycle.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            USER_UPD     <= '0;
            USER_UPD_STB <= 1'b0;
        end else begin
            USER_UPD_STB <= 1'b0;
            if (state == UPDATE_DR && dr_sel == DR_USER) begin
                USER_UPD     <= user_shift;
                USER_UPD_STB <= 1'b1;
            end
        end
    end

    always_comb begin
        dr_lsb = bypass_reg;
        case (dr_sel)
            DR_IDCODE: dr_lsb = idcode_shift[0];
            DR_USER:   dr_lsb = user_shift[0];
            default:   ;
        endcase
        tdo_nxt = 1'b0;
        if (state == SHIFT_DR) begin
            tdo_nxt = dr_lsb;
        end else if (state == SHIFT_IR) begin
            tdo_nxt = ir_shift[0];
        end
    end

    // Falling-edge output stage gives the far end half a TCK of setup before its next sample.
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            TDO    <= 1'b0;
            TDO_EN <= 1'b0;
        end else begin
            TDO    <= tdo_nxt;
            TDO_EN <= is_shift_state(state);
        end
    end

endmodule

// File: tb/tb_jtag_tap_core.sv
// Bench for jtag_tap_core: directed scans plus random TMS/TDI traffic against a queue-based TAP model.
// Expected TDO bits are queued by the driver and consumed by an independent monitor while TDO_EN is high.
module tb_jtag_tap_core;

    localparam int          IRW        = 4;
    localparam int          UW         = 8;
    localparam int          IRW2       = 6;
    localparam int          UW2        = 1;
    localparam logic [31:0] IDCODE_EXP = 32'h1577_B001;
    localparam int          IDC        = 1;
    localparam int          USR        = 2;

    logic            TCK;
    logic            TRST;
    logic            TMS;
    logic            TDI;
    logic            TDO;
    logic            TDO_EN;
    logic [3:0]      STATE;
    logic [IRW-1:0]  IR_OUT;
    logic [UW-1:0]   USER_CAP;
    logic [UW-1:0]   USER_UPD;
    logic            USER_UPD_STB;

    logic            tdo2;
    logic            tdo_en2;
    logic [3:0]      state2;
    logic [IRW2-1:0] ir_out2;
    logic [UW2-1:0]  user_cap2;
    logic [UW2-1:0]  user_upd2;
    logic            user_upd_stb2;

    jtag_tap_core #(.IR_WIDTH(IRW), .USER_WIDTH(UW)) dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
        .STATE(STATE), .IR_OUT(IR_OUT), .USER_CAP(USER_CAP), .USER_UPD(USER_UPD),
        .USER_UPD_STB(USER_UPD_STB)
    );

    jtag_tap_core #(.IR_WIDTH(IRW2), .USER_WIDTH(UW2)) dut2 (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(tdo2), .TDO_EN(tdo_en2),
        .STATE(state2), .IR_OUT(ir_out2), .USER_CAP(user_cap2), .USER_UPD(user_upd2),
        .USER_UPD_STB(user_upd_stb2)
    );

    initial begin
        TCK = 1'b0;
        forever #5 TCK = ~TCK;
    end

    int checks   = 0;
    int failures = 0;

    // IEEE 1149.1 transition table, indexed by state number.
    int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    int m_state;
    int m_ir;
    int m_upd;
    bit m_stb;
    bit q_ir  [$];
    bit q_dr  [$];
    bit exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_ir    = IDC;
        m_upd   = 0;
        m_stb   = 0;
        q_ir.delete();
        q_dr.delete();
        exp_q.delete();
    endtask

    task automatic model_step(input bit tms, input bit tdi);
        int s;
        s     = m_state;
        m_stb = 0;
        case (s)
            0: m_ir = IDC;
            3: begin
                q_dr.delete();
                if (m_ir == IDC)      for (int i = 0; i < 32; i++) q_dr.push_back(IDCODE_EXP[i]);
                else if (m_ir == USR) for (int i = 0; i < UW; i++) q_dr.push_back(USER_CAP[i]);
                else                  q_dr.push_back(1'b0);
            end
            4: begin
                void'(q_dr.pop_front());
                q_dr.push_back(tdi);
            end
            8: if (m_ir == USR) begin
                m_upd = 0;
                foreach (q_dr[i]) m_upd |= int'(q_dr[i]) << i;
                m_stb = 1;
            end
            10: begin
                q_ir.delete();
                q_ir.push_back(1'b1);
                for (int i = 1; i < IRW; i++) q_ir.push_back(1'b0);
            end
            11: begin
                void'(q_ir.pop_front());
                q_ir.push_back(tdi);
            end
            15: begin
                m_ir = 0;
                foreach (q_ir[i]) m_ir |= int'(q_ir[i]) << i;
            end
            default: ;
        endcase
        m_state = tms ? nxt1[s] : nxt0[s];
        if (m_state == 4)       exp_q.push_back(q_dr[0]);
        else if (m_state == 11) exp_q.push_back(q_ir[0]);
    endtask

    task automatic tick(input bit tms, input bit tdi);
        @(negedge TCK);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        #1;
        model_step(tms, tdi);
        check("state", STATE, m_state);
        check("state_w6", state2, m_state);
        check("ir_out", IR_OUT, m_ir);
        check("user_upd", USER_UPD, m_upd);
        check("user_upd_stb", USER_UPD_STB, m_stb);
        if (exp_q.size() > 1) check("tdo_backlog", exp_q.size(), 1);
    endtask

    task automatic pulse_trst();
        #2;
        TRST = 1'b1;
        model_reset();
        #1;
        check("trst_state", STATE, 0);
        check("trst_ir_out", IR_OUT, IDC);
        check("trst_tdo", TDO, 0);
        check("trst_tdo_en", TDO_EN, 0);
        check("trst_user_upd", USER_UPD, 0);
        check("trst_stb", USER_UPD_STB, 0);
        repeat (3) @(posedge TCK);
        #1;
        check("trst_hold_state", STATE, 0);
        check("trst_ir_out_w6", ir_out2, 1);
        TRST = 1'b0;
    endtask

    task automatic goto_rti();
        repeat (5) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic load_ir(input int val);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < IRW; i++) tick(i == IRW - 1, val[i]);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic scan_dr(input logic [63:0] data, input int n, input int pause_at);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) begin
                tick(1'b1, data[i]);
            end else if (i == pause_at) begin
                tick(1'b1, data[i]);
                tick(1'b0, 1'b0);
                tick(1'b0, 1'b0);
                tick(1'b1, 1'b0);
                tick(1'b0, 1'b0);
            end else begin
                tick(1'b0, data[i]);
            end
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // Monitor: TDO is stable mid-low-phase; every enabled bit must match the oldest expectation.
    initial begin
        bit b;
        forever begin
            @(negedge TCK);
            #2;
            if (TDO_EN === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("tdo_unexpected_en", TDO_EN, 0);
                end else begin
                    b = exp_q.pop_front();
                    check("tdo_bit", TDO, b);
                end
            end else begin
                check("tdo_idle", TDO, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench did not complete");
    end

    initial begin
        int op;
        TRST      = 1'b0;
        TMS       = 1'b1;
        TDI       = 1'b0;
        USER_CAP  = '0;
        user_cap2 = '0;
        model_reset();

        pulse_trst();
        tick(1'b0, 1'b0);

        // IDCODE readout straight after reset
        scan_dr(64'h0, 32, 99);

        // IR capture pattern 1,0 then BYPASS with 1011_0010 shifted LSB-first
        load_ir(4'hF);
        scan_dr(64'hB2, 8, 99);

        // TRST part-way through a USER shift discards the operation
        load_ir(USR);
        USER_CAP = 8'h5A;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        repeat (4) tick(1'b0, 1'b1);
        pulse_trst();
        tick(1'b0, 1'b0);

        // USER capture A5 out, 3C in and updated
        load_ir(USR);
        USER_CAP = 8'hA5;
        scan_dr(64'h3C, 8, 99);
        check("user_upd_3c", USER_UPD, 8'h3C);

        // Five TMS=1 from SHIFT_IR, then one more edge in TEST_LOGIC_RESET
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        repeat (5) tick(1'b1, 1'b0);
        check("tlr_state_w6", state2, 0);
        tick(1'b1, 1'b0);
        check("tlr_ir_out_w6", ir_out2, 1);
        tick(1'b0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            op        = $urandom_range(0, 9);
            USER_CAP  = UW'($urandom);
            user_cap2 = UW2'($urandom);
            if (op < 3) begin
                case ($urandom_range(0, 3))
                    0:       load_ir(IDC);
                    1:       load_ir(USR);
                    2:       load_ir((1 << IRW) - 1);
                    default: load_ir($urandom_range(0, (1 << IRW) - 1));
                endcase
            end else if (op < 8) begin
                scan_dr({$urandom, $urandom}, $urandom_range(1, 40), $urandom_range(0, 40));
            end else if (op == 8) begin
                repeat (12) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                goto_rti();
            end else begin
                tick(1'b1, 1'b0);
                tick(1'b0, 1'b0);
                tick(1'b0, 1'b0);
                repeat ($urandom_range(0, 6)) tick(1'b0, 1'($urandom_range(0, 1)));
                pulse_trst();
                goto_rti();
            end
        end

        @(negedge TCK);
        #3;
        check("tdo_queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtag_tap_core.md
# jtag_tap_core

Parametrised JTAG TAP: the 16-state TAP controller plus a parametrised instruction register, 1-bit BYPASS, 32-bit IDCODE and one user data register with parallel capture and update ports. It is the next generation of the bare TAP state machine and sits between the chip's JTAG pins and on-chip debug/test logic. State encoding, and therefore STATE trace compatibility, is unchanged from the existing TAP controller.

## Interface
- IR_WIDTH, 4: instruction register length; legal range 2..8.
- IDCODE_VAL, 32'h1577_B001: IDCODE register value; bit 0 must be 1.
- IDCODE_INSTR, 4'b0001: opcode that selects IDCODE. Zero-extended or truncated to IR_WIDTH.
- USER_INSTR, 4'b0010: opcode that selects the user data register. Zero-extended or truncated to IR_WIDTH.
- USER_WIDTH, 8: user data register length; range 1..32.
- TCK  in  1  test clock; the only clock.
- TRST  in  1  reset, asynchronous, active-high.
- TMS  in  1  mode select, sampled on posedge TCK.
- TDI  in  1  serial data in, sampled on posedge TCK.
- TDO  out  1  serial data out; changes on negedge TCK.
- TDO_EN  out  1  high while STATE is SHIFT_DR or SHIFT_IR; registered on negedge TCK.
- STATE  out  4  current TAP state, using the encodings 0000 (TEST_LOGIC_RESET) .. 1111 (UPDATE_IR).
- IR_OUT  out  IR_WIDTH  active instruction.
- USER_CAP  in  USER_WIDTH  parallel value captured in CAPTURE_DR when USER is selected.
- USER_UPD  out  USER_WIDTH  value latched in UPDATE_DR when USER is selected.
- USER_UPD_STB  out  1  one-TCK pulse, asserted in the cycle USER_UPD changes.

## Operation
- FSM: standard IEEE 1149.1 transitions on posedge TCK, driven by TMS. Five consecutive TMS=1 edges reach TEST_LOGIC_RESET from any state.
- All register actions below fire on the posedge at which STATE currently holds the named state.
- CAPTURE_IR: IR shift register loads {0…0,2'b01}.
- SHIFT_IR: shift register shifts right; TDI enters the MSB; the LSB goes to TDO.
- UPDATE_IR: IR_OUT loads the shift register contents.
- TEST_LOGIC_RESET (any posedge, including at power-up): IR_OUT is set to IDCODE_INSTR.
- DR selection by IR_OUT:
  - IDCODE_INSTR selects the 32-bit IDCODE register; capture loads IDCODE_VAL.
  - USER_INSTR selects the USER_WIDTH user register; capture loads USER_CAP.
  - Any other opcode, all-ones included, selects BYPASS; capture loads 0.
- SHIFT_DR: the selected register shifts right with TDI into its MSB.
- UPDATE_DR with USER selected: USER_UPD is loaded from the user shift register and USER_UPD_STB is high for that cycle.
- UPDATE_DR with IDCODE or BYPASS selected: no update side effect.
- TDO is updated on negedge TCK:
  - in SHIFT_DR, from the LSB of the selected DR;
  - in SHIFT_IR, from the LSB of the IR shift register;
  - in every other state, holds 0.
- TRST high (asynchronous):
  - STATE=0000, IR_OUT=IDCODE_INSTR, all shift registers 0, USER_UPD=0;
  - USER_UPD_STB=0, TDO=0, TDO_EN=0.
  - An operation interrupted by TRST is discarded; there is no partial update.

## Timing
- STATE follows TMS with a latency of one posedge.
- The first TDO bit of a shift is the LSB captured in CAPTURE_xR. It appears on the negedge after the CAPTURE→SHIFT transition.
- BYPASS delays TDI by exactly 1 TCK; IDCODE delays by 32; USER delays by USER_WIDTH.
- IR_OUT changes on the posedge that leaves UPDATE_IR. DR selection uses the new IR from the next CAPTURE_DR onward.
- Simultaneous TRST and TCK edge: TRST wins.
- TMS/TDI must be stable around posedge; the bench drives them on negedge.

## Structure
- Package jtag_pkg holds:
  - the 16 state localparams (the same encodings as the existing TAP controller);
  - the IR capture constant 2'b01;
  - the BYPASS capture value.
- Sub-module jtag_tap_fsm contains the state register and next-state logic (TCK, TRST, TMS → STATE). It is reusable standalone.
- jtag_tap_core instantiates jtag_tap_fsm and holds the IR, the DRs, the decode and the TDO mux.

## Test plan
- Reset: TRST=1 for 3 edges → STATE=0000, IR_OUT=0001, TDO=0, TDO_EN=0. Deassert, TMS=0 → STATE=0001.
- IDCODE: after reset, run RTI→SELECT_DR→CAPTURE_DR→SHIFT_DR and shift 32 bits → TDO LSB-first reads 32'h1577_B001.
- IR capture/BYPASS: load IR=1111 via SHIFT_IR; the first two TDO bits during that shift are 1 then 0. Then shift TDI=1011_0010 through DR → TDO shows the same stream delayed by 1 TCK, with first bit 0.
- USER: IR=0010, USER_CAP=8'hA5 → shifted-out byte is A5. Shifting in 8'h3C then passing UPDATE_DR → USER_UPD=3C with USER_UPD_STB pulsed for exactly 1 cycle.
- TRST mid-SHIFT_DR (USER selected, 4 bits in) → STATE=0000 immediately, USER_UPD unchanged (0), IR_OUT=0001.
- From SHIFT_IR, five TMS=1 edges → STATE=0000 and IR_OUT=0001. Repeat the check with IR_WIDTH=6 and USER_WIDTH=1.
